dense_layer: RTL and testbench

- Fully connected output stage directly downstream of the CNN flattening stage; implements the DENSE and OUTPUT steps.
- Latches one flattened feature vector on start and streams it one element per cycle through NUM_CLASSES parallel multiply-accumulate lanes.
- Lane weights are signed 2-bit values held in an on-block weight store written from outside the chip.
- After accumulation, performs a sequential argmax and reports the per-class scores and the winning class index.

---
 rtl/dense_layer_pkg.sv | 29 ++
 rtl/dense_layer_mac.sv | 42 ++++
 rtl/dense_layer.sv | 188 ++++++++++++++++++
 tb/tb_dense_layer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_layer_pkg.sv
// Shared types and constants for the CNN dense output stage (package cnn_pkg).
// Optional feature macro: DENSE_BIAS_EN (per-class bias registers, one extra accumulator bit).
package cnn_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
`ifdef DENSE_BIAS_EN
    localparam int unsigned DEFAULT_ACC_WIDTH  = 17;
`else
    localparam int unsigned DEFAULT_ACC_WIDTH  = 16;
`endif

    // Signed 2-bit lane weight: -2, -1, 0, +1
    typedef logic signed [1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } dense_state_t;

    // Smallest accumulator width that cannot overflow for the given shape
    function automatic int unsigned dense_min_acc_width(input int unsigned data_width,
                                                        input int unsigned in_length,
                                                        input bit          bias_en);
        return data_width + 2 + $clog2(in_length) + {31'd0, bias_en};
    endfunction

endpackage

// File: rtl/dense_layer_mac.sv
// One multiply-accumulate lane: unsigned element times signed 2-bit weight.
module dense_mac
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_dense,
    input  logic                        load,
    input  logic signed [ACC_WIDTH-1:0] load_val,
    input  logic                        en,
    input  logic [DATA_WIDTH-1:0]       x,
    input  weight_t                     w,
    output logic signed [ACC_WIDTH-1:0] acc
);

    localparam int unsigned PROD_W = DATA_WIDTH + 2;

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;

    // Full-precision product; magnitude never exceeds 2*(2^DATA_WIDTH-1)
    always_comb begin
        x_ext = PROD_W'($signed({1'b0, x}));
        w_ext = PROD_W'(w);
        prod  = x_ext * w_ext;
    end

    // Accumulator: reset, then load, then accumulate
    always_ff @(posedge clk) begin
        if (rst_dense) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/dense_layer.sv
// Fully connected output stage: streams a latched feature vector through
// NUM_CLASSES MAC lanes, then picks the highest-scoring class (lowest index on ties).
// Optional feature macro: DENSE_BIAS_EN (bias written at weight_index == IN_LENGTH).
module dense_layer
    import cnn_pkg::*;
#(
    parameter int unsigned IN_LENGTH   = 50,
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEFAULT_ACC_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_dense,
    input  logic [IN_LENGTH*DATA_WIDTH-1:0]     in_vec,
    input  logic                                start,
    input  logic                                weight_WrEn,
    input  logic [$clog2(NUM_CLASSES)-1:0]      weight_class,
    input  logic [$clog2(IN_LENGTH+1)-1:0]      weight_index,
    input  logic [ACC_WIDTH-1:0]                weight_data,
    output logic                                busy,
    output logic                                done,
    output logic [ACC_WIDTH*NUM_CLASSES-1:0]    scores,
    output logic [$clog2(NUM_CLASSES)-1:0]      class_out
);

    localparam int unsigned CLS_W = $clog2(NUM_CLASSES);
    localparam int unsigned CNT_W = (IN_LENGTH > NUM_CLASSES) ? $clog2(IN_LENGTH) : $clog2(NUM_CLASSES);
`ifdef DENSE_BIAS_EN
    localparam bit BIAS_EN = 1'b1;
`else
    localparam bit BIAS_EN = 1'b0;
`endif

    if (ACC_WIDTH < dense_min_acc_width(DATA_WIDTH, IN_LENGTH, BIAS_EN)) begin : g_acc_width_check
        $error("dense_layer: ACC_WIDTH too small for DATA_WIDTH/IN_LENGTH");
    end

    dense_state_t                state;
    dense_state_t                state_next;
    logic [CNT_W-1:0]            idx;
    logic [DATA_WIDTH-1:0]       vec  [IN_LENGTH];
    weight_t                     wmem [NUM_CLASSES][IN_LENGTH];
    logic signed [ACC_WIDTH-1:0] acc      [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0] load_val [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0] max_val;
    logic [CLS_W-1:0]            max_idx;
    logic [CLS_W-1:0]            arg_idx;
    logic                        last_elem;
    logic                        last_class;
    logic                        wr_ok;
    logic                        start_acc;
    logic                        mac_en;
    logic [DATA_WIDTH-1:0]       cur_x;

    // Shared decode used by FSM, datapath and weight store
    always_comb begin
        last_elem  = (idx == CNT_W'(IN_LENGTH - 1));
        last_class = (idx == CNT_W'(NUM_CLASSES - 1));
        arg_idx    = CLS_W'(idx);
        wr_ok      = (state == IDLE) && weight_WrEn && (32'(weight_class) < NUM_CLASSES);
        start_acc  = (state == IDLE) && start;
        mac_en     = (state == ACCUM);
        cur_x      = vec[idx];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_dense) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = ACCUM;
            ACCUM:   if (last_elem)  state_next = ARGMAX;
            ARGMAX:  if (last_class) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Counter, vector latch, running argmax and registered outputs
    always_ff @(posedge clk) begin
        if (rst_dense) begin
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            max_val   <= '0;
            max_idx   <= '0;
            scores    <= '0;
            class_out <= '0;
            for (int k = 0; k < IN_LENGTH; k++) vec[k] <= '0;
        end else begin
            busy <= (state_next == ACCUM) || (state_next == ARGMAX);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
                        for (int k = 0; k < IN_LENGTH; k++) vec[k] <= in_vec[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ACCUM: begin
                    idx <= last_elem ? '0 : idx + CNT_W'(1);
                end
                ARGMAX: begin
                    idx <= idx + CNT_W'(1);
                    if ((idx == '0) || (acc[arg_idx] > max_val)) begin
                        max_val <= acc[arg_idx];
                        max_idx <= arg_idx;
                    end
                end
                DONE: begin
                    idx       <= '0;
                    done      <= 1'b1;
                    class_out <= max_idx;
                    for (int c = 0; c < NUM_CLASSES; c++) scores[c*ACC_WIDTH +: ACC_WIDTH] <= acc[c];
                end
                default: idx <= '0;
            endcase
        end
    end

    // Weight store, writable only while idle
    always_ff @(posedge clk) begin
        if (rst_dense) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                for (int k = 0; k < IN_LENGTH; k++) wmem[c][k] <= '0;
        end else if (wr_ok && (32'(weight_index) < IN_LENGTH)) begin
            wmem[weight_class][weight_index] <= weight_t'(weight_data[1:0]);
        end
    end

`ifdef DENSE_BIAS_EN
    logic signed [ACC_WIDTH-1:0] bias [NUM_CLASSES];
    logic                        bias_wr;

    always_comb bias_wr = wr_ok && (32'(weight_index) == IN_LENGTH);

    // Bias store
    always_ff @(posedge clk) begin
        if (rst_dense) begin
            for (int c = 0; c < NUM_CLASSES; c++) bias[c] <= '0;
        end else if (bias_wr) begin
            bias[weight_class] <= $signed(weight_data);
        end
    end

    // Accumulator preload; a bias written on the start edge is forwarded
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            load_val[c] = bias[c];
            if (bias_wr && (32'(weight_class) == c)) load_val[c] = $signed(weight_data);
        end
    end
`else
    logic unused_data_bits;

    always_comb unused_data_bits = ^weight_data[ACC_WIDTH-1:2];

    // Accumulators always start from zero
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) load_val[c] = '0;
    end
`endif

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
        dense_mac #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_mac (
            .clk       (clk),
            .rst_dense (rst_dense),
            .load      (start_acc),
            .load_val  (load_val[c]),
            .en        (mac_en),
            .x         (cur_x),
            .w         (wmem[c][idx]),
            .acc       (acc[c])
        );
    end

endmodule

// File: tb/tb_dense_layer.sv
// Self-checking bench for dense_layer: directed vector table plus corner sequences.
module tb_dense_layer;

    localparam int unsigned IN_LEN = 50;
    localparam int unsigned NC     = 4;
    localparam int unsigned DW     = 8;
`ifdef DENSE_BIAS_EN
    localparam int unsigned AW     = 17;
`else
    localparam int unsigned AW     = 16;
`endif
    localparam int LAT = IN_LEN + NC + 1;

    logic                 clk = 1'b0;
    logic                 rst_dense;
    logic [IN_LEN*DW-1:0] in_vec;
    logic                 start;
    logic                 weight_WrEn;
    logic [1:0]           weight_class;
    logic [5:0]           weight_index;
    logic [AW-1:0]        weight_data;
    logic                 busy;
    logic                 done;
    logic [AW*NC-1:0]     scores;
    logic [1:0]           class_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dense_layer #(
        .IN_LENGTH   (IN_LEN),
        .NUM_CLASSES (NC),
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk          (clk),
        .rst_dense    (rst_dense),
        .in_vec       (in_vec),
        .start        (start),
        .weight_WrEn  (weight_WrEn),
        .weight_class (weight_class),
        .weight_index (weight_index),
        .weight_data  (weight_data),
        .busy         (busy),
        .done         (done),
        .scores       (scores),
        .class_out    (class_out)
    );

    typedef struct packed {
        int w0, w1, w2, w3;
        int x;
        int s0, s1, s2, s3;
        int cls;
    } vec_t;

    task automatic check(input string name, input logic signed [31:0] actual, input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic signed [31:0] score(input int c);
        logic signed [AW-1:0] s;
        s = scores[c*AW +: AW];
        return 32'(s);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_w(input int c, input int k, input int val);
        weight_WrEn  = 1'b1;
        weight_class = 2'(c);
        weight_index = 6'(k);
        weight_data  = AW'(val);
        tick();
        weight_WrEn  = 1'b0;
    endtask

    task automatic load_all(input int w0, input int w1, input int w2, input int w3);
        int ws [4];
        ws = '{w0, w1, w2, w3};
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < IN_LEN; k++) write_w(c, k, ws[c]);
    endtask

    task automatic set_vec(input int v);
        for (int k = 0; k < IN_LEN; k++) in_vec[k*DW +: DW] = DW'(v);
    endtask

    // Pulses start and returns posedges from the accepting edge to done (bounded)
    task automatic run(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_scores(input string tag, input int s0, input int s1, input int s2, input int s3);
        int es [4];
        es = '{s0, s1, s2, s3};
        for (int c = 0; c < 4; c++) check($sformatf("%s_score%0d", tag, c), score(c), es[c]);
    endtask

    vec_t tv [6];

    initial begin
        int lat;
        int dones;
        int first_done;

        tv[0] = '{0, 0, 1, 0,    3,      0,     0, 150,     0, 2};
        tv[1] = '{-1, 1, 0, 0, 255, -12750, 12750,   0,     0, 1};
        tv[2] = '{1, 1, 1, 1,    1,     50,    50,  50,    50, 0};
        tv[3] = '{-2, -1, -2, -1, 2,  -200,  -100, -200, -100, 1};
        tv[4] = '{1, 1, -2, 1,   0,      0,     0,   0,     0, 0};
        tv[5] = '{0, 0, 0, 1,  255,      0,     0,   0, 12750, 3};

        rst_dense = 1'b1; start = 1'b0; weight_WrEn = 1'b0;
        weight_class = '0; weight_index = '0; weight_data = '0; in_vec = '0;
        tick(); tick();
        rst_dense = 1'b0;

        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_class", 32'(class_out), 0);
        check_scores("reset", 0, 0, 0, 0);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            load_all(tv[i].w0, tv[i].w1, tv[i].w2, tv[i].w3);
            set_vec(tv[i].x);
            run(lat);
            check($sformatf("v%0d_latency", i), lat, LAT);
            check_scores($sformatf("v%0d", i), tv[i].s0, tv[i].s1, tv[i].s2, tv[i].s3);
            check($sformatf("v%0d_class", i), 32'(class_out), tv[i].cls);
            tick();
            check($sformatf("v%0d_done_pulse", i), 32'(done), 0);
        end

        // Weight write on the same edge as start is used from element 0
        load_all(0, 0, 0, 0);
        set_vec(1);
        weight_WrEn = 1'b1; weight_class = 2'd1; weight_index = 6'd0; weight_data = AW'(1);
        start = 1'b1;
        tick();
        start = 1'b0; weight_WrEn = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin tick(); lat++; end
        check("same_edge_latency", lat, LAT);
        check_scores("same_edge", 0, 1, 0, 0);
        check("same_edge_class", 32'(class_out), 1);

        // Second start and weight write during ACCUM are both dropped
        load_all(0, 0, 1, 0);
        set_vec(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0; first_done = -1;
        for (int n = 1; n <= 120; n++) begin
            if (n == 10) begin
                start = 1'b1;
                weight_WrEn = 1'b1; weight_class = 2'd0; weight_index = 6'd0; weight_data = AW'(1);
            end
            tick();
            start = 1'b0; weight_WrEn = 1'b0;
            if (n == 30) check("busy_mid_accum", 32'(busy), 1);
            if (done) begin
                dones++;
                if (first_done < 0) first_done = n;
            end
        end
        check("busy_start_done_count", dones, 1);
        check("busy_start_latency", first_done, LAT);
        check_scores("busy_start", 0, 0, 150, 0);

        // Scores hold during a later inference; dropped write stays invisible
        set_vec(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("hold_mid_score2", score(2), 150);
        check("hold_mid_class", 32'(class_out), 2);
        lat = 20;
        while (!done && lat < 200) begin tick(); lat++; end
        check("hold_latency", lat, LAT);
        check_scores("dropped_write", 0, 0, 50, 0);

        // Reset mid-ACCUM discards the inference and clears weights
        set_vec(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst_dense = 1'b1;
        tick();
        rst_dense = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_class", 32'(class_out), 0);
        check_scores("midrst", 0, 0, 0, 0);
        dones = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run(lat);
        check("midrst_rerun_latency", lat, LAT);
        check_scores("weights_cleared", 0, 0, 0, 0);
        check("weights_cleared_class", 32'(class_out), 0);

`ifdef DENSE_BIAS_EN
        // Bias preloads the accumulator
        load_all(0, 0, 0, 1);
        write_w(3, IN_LEN, -5);
        set_vec(0);
        run(lat);
        check("bias_latency", lat, LAT);
        check_scores("bias", 0, 0, 0, -5);
        check("bias_class", 32'(class_out), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
